seq_stream_checker: RTL

- Receive-side checker for the 4-bit load/increment counter stream (DOUT plus its XOR parity).
- Each cycle it predicts the next word from the previous word and the load controls, then compares the prediction with the observed word.
- It acquires and loses lock through a small state machine and keeps saturating error statistics for the status/debug path.

---
 rtl/seq_stream_checker_if.sv | 43 ++++
 rtl/seq_stream_checker.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seq_stream_checker_if.sv
// seq_stream_checker_if
// Purpose: groups the observed stream, the load controls and the checker status outputs into
//          one bundle.
// Signals:
//   en       sample qualifier
//   sel, ld  load control and load value driven to the producer this cycle
//   data     observed producer word
//   par_in   received XOR parity of data
//   clr      synchronous clear of the statistics
//   locked   checker is in the LOCKED state
//   err      one-cycle data-mismatch pulse (LOCKED only)
//   par_err  one-cycle parity-mismatch pulse
//   err_cnt  saturating count of err pulses
//   par_cnt  saturating count of par_err pulses
//   sticky   set by any err/par_err, cleared by clr or reset
// Modports: master drives the stream side, slave is the checker.
interface seq_stream_checker_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             sel;
    logic [WIDTH-1:0] ld;
    logic [WIDTH-1:0] data;
    logic             par_in;
    logic             clr;
    logic             locked;
    logic             err;
    logic             par_err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] par_cnt;
    logic             sticky;

    modport master (
        output en, sel, ld, data, par_in, clr,
        input  locked, err, par_err, err_cnt, par_cnt, sticky
    );

    modport slave (
        input  en, sel, ld, data, par_in, clr,
        output locked, err, par_err, err_cnt, par_cnt, sticky
    );
endinterface

// File: rtl/seq_stream_checker.sv
// seq_stream_checker
// Purpose: receive-side checker for a load/increment counter stream. Each enabled cycle it
//          predicts the next word from the previous word and the load controls, compares the
//          observed word with the prediction, acquires/loses lock through a HUNT/LOCKED state
//          machine and keeps saturating error statistics.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   io_bus   seq_stream_checker_if.slave: stream inputs and status outputs
module seq_stream_checker #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned LOCK_MATCHES = 3,
    parameter int unsigned MISS_MAX     = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    seq_stream_checker_if.slave  io_bus
);
    localparam logic [3:0] LockMatchesC = 4'(LOCK_MATCHES);
    localparam logic [3:0] MissMaxC     = 4'(MISS_MAX);

    typedef enum logic [0:0] {StHunt, StLocked} state_e;

    state_e             r_state,     w_state_d;
    logic [WIDTH-1:0]   r_exp,       w_exp_d;
    logic               r_exp_v,     w_exp_v_d;
    logic [3:0]         r_match_cnt, w_match_cnt_d;
    logic [3:0]         r_miss_cnt,  w_miss_cnt_d;
    logic               r_err,       w_err_d;
    logic               r_par_err,   w_par_err_d;
    logic [CNT_W-1:0]   r_err_cnt,   w_err_cnt_d;
    logic [CNT_W-1:0]   r_par_cnt,   w_par_cnt_d;
    logic               r_sticky,    w_sticky_d;
    logic               r_locked;

    logic               w_match;
    logic               w_par_bad;
    logic [3:0]         w_match_inc;
    logic [3:0]         w_miss_inc;

    assign w_match     = r_exp_v && (io_bus.data == r_exp);
    assign w_par_bad   = io_bus.par_in != (^io_bus.data);
    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_miss_inc  = r_miss_cnt + 4'd1;

    always_comb begin
        w_state_d     = r_state;
        w_exp_d       = r_exp;
        w_exp_v_d     = r_exp_v;
        w_match_cnt_d = r_match_cnt;
        w_miss_cnt_d  = r_miss_cnt;
        w_err_d       = 1'b0;
        w_par_err_d   = 1'b0;
        w_err_cnt_d   = r_err_cnt;
        w_par_cnt_d   = r_par_cnt;
        w_sticky_d    = r_sticky;

        if (io_bus.en) begin
            w_exp_v_d   = 1'b1;
            w_par_err_d = w_par_bad;

            unique case (r_state)
                StHunt: begin
                    // Re-seed from the observed word while hunting.
                    w_exp_d = io_bus.sel ? io_bus.ld : io_bus.data + WIDTH'(1);
                    if (r_exp_v) begin
                        if (w_match) begin
                            if (w_match_inc >= LockMatchesC) begin
                                w_state_d     = StLocked;
                                w_match_cnt_d = 4'd0;
                                w_miss_cnt_d  = 4'd0;
                            end else begin
                                w_match_cnt_d = w_match_inc;
                            end
                        end else begin
                            w_match_cnt_d = 4'd0;
                        end
                    end
                end
                StLocked: begin
                    // Free-run from the prediction so a corrupt word does not poison it.
                    w_exp_d = io_bus.sel ? io_bus.ld : r_exp + WIDTH'(1);
                    if (r_exp_v && !w_match) begin
                        w_err_d = 1'b1;
                        if (w_miss_inc >= MissMaxC) begin
                            w_state_d     = StHunt;
                            w_match_cnt_d = 4'd0;
                            w_miss_cnt_d  = 4'd0;
                        end else begin
                            w_miss_cnt_d = w_miss_inc;
                        end
                    end else if (w_match) begin
                        w_miss_cnt_d = 4'd0;
                    end
                end
                default: w_state_d = StHunt;
            endcase

            // Clear beats a coincident error for the statistics; the pulses still fire.
            if (io_bus.clr) begin
                w_err_cnt_d = '0;
                w_par_cnt_d = '0;
                w_sticky_d  = 1'b0;
            end else begin
                if (w_err_d && !(&r_err_cnt)) begin
                    w_err_cnt_d = r_err_cnt + CNT_W'(1);
                end
                if (w_par_err_d && !(&r_par_cnt)) begin
                    w_par_cnt_d = r_par_cnt + CNT_W'(1);
                end
                w_sticky_d = r_sticky | w_err_d | w_par_err_d;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StHunt;
            r_exp       <= '0;
            r_exp_v     <= 1'b0;
            r_match_cnt <= 4'd0;
            r_miss_cnt  <= 4'd0;
            r_err       <= 1'b0;
            r_par_err   <= 1'b0;
            r_err_cnt   <= '0;
            r_par_cnt   <= '0;
            r_sticky    <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_exp       <= w_exp_d;
            r_exp_v     <= w_exp_v_d;
            r_match_cnt <= w_match_cnt_d;
            r_miss_cnt  <= w_miss_cnt_d;
            r_err       <= w_err_d;
            r_par_err   <= w_par_err_d;
            r_err_cnt   <= w_err_cnt_d;
            r_par_cnt   <= w_par_cnt_d;
            r_sticky    <= w_sticky_d;
            r_locked    <= (w_state_d == StLocked);
        end
    end

    assign io_bus.locked  = r_locked;
    assign io_bus.err     = r_err;
    assign io_bus.par_err = r_par_err;
    assign io_bus.err_cnt = r_err_cnt;
    assign io_bus.par_cnt = r_par_cnt;
    assign io_bus.sticky  = r_sticky;
endmodule
